fft_cmul_pipe: RTL and testbench
================================

Name: fft_cmul_pipe

Overview:
- Parametrised, pipelined signed complex multiplier: next generation of the FFT-stage real DSP48 multiplier (24x15 signed product, 2-register pipeline, ce stall).
- Computes x*w or x*conj(w) for the FFT twiddle/butterfly path, with round-half-up, right shift, saturation to output width, valid tracking and a sticky saturation flag.
- Sits between the twiddle ROM and the butterfly adders in fft_top. Fully pipelined: one sample per clock when ce=1.

Parameters:
- DIN_W, 24, signed width of each data component (xr, xi).
- TW_W, 15, signed width of each twiddle component (wr, wi), Q1.(TW_W-1).
- DOUT_W, 24, signed width of each output component.
- SHIFT, 14, arithmetic right shift applied after rounding; legal range 1..DIN_W+TW_W.
- USER_W, 8, sideband width passed through aligned with data.

Ports:
- clk, in, 1, rising-edge clock.
- reset_n, in, 1, synchronous active-low reset.
- ce, in, 1, global clock enable; 0 freezes every pipeline register, including valid and sideband.
- in_valid, in, 1, input sample qualifier.
- conj, in, 1, 1 selects x*conj(w); sampled with the data.
- xr, xi, in, DIN_W each, data real/imag.
- wr, wi, in, TW_W each, twiddle real/imag.
- in_user, in, USER_W, sideband (e.g. bin index/tlast).
- out_valid, out, 1, output qualifier.
- yr, yi, out, DOUT_W each, result real/imag.
- out_user, out, USER_W, sideband delayed to match yr/yi.
- sat, out, 1, sticky: 1 once any valid output component has saturated.
- sat_clr, in, 1, clears sat (sampled when ce=1).

Behaviour:
- Reset (reset_n=0 at clk edge, regardless of ce): all pipeline valid bits, out_valid, yr, yi, out_user and sat go to 0. Data stage registers also clear. A sample in flight is discarded.
- Pipeline with latency 4 clocks of ce=1:
  - S1: register xr, xi, wr, wi, conj, in_user, in_valid.
  - S2: four full-width products: pp_rr=xr*wr, pp_ii=xi*wi, pp_ir=xi*wr, pp_ri=xr*wi. Each product is DIN_W+TW_W bits.
  - S3: sums at width P=DIN_W+TW_W+1.
    - conj=0: re=pp_rr-pp_ii, im=pp_ir+pp_ri.
    - conj=1: re=pp_rr+pp_ii, im=pp_ir-pp_ri.
  - S4: round, shift, saturate, then register outputs.
    - t=(s + 2^(SHIFT-1)) >>> SHIFT, computed at width P+1 with no intermediate overflow.
    - If t > 2^(DOUT_W-1)-1, output the max value; if t < -2^(DOUT_W-1), output the min value; otherwise output t truncated to DOUT_W.
    - Rounding is half toward +inf (-1.5 -> -1, 1.5 -> 2).
- Output hold: out_valid follows in_valid exactly 4 ce-cycles later. yr, yi and out_user update only when the S4 valid bit is 1; otherwise they hold their previous value.
- ce=0: no register changes, outputs hold. in_valid asserted while ce=0 is ignored.
- sat flag:
  - Set when an S4 valid sample saturates either component.
  - sat_clr=1 with ce=1 clears sat. If a saturation event occurs in the same cycle as sat_clr, set wins and sat=1.
- Back-to-back valid samples are accepted every ce cycle, with no bubbles. Gaps in in_valid propagate as out_valid=0 gaps.
- Functionally exact versus the bit-true model. No dependency on DSP48 inference, but each S2 product must map to one DSP at the defaults.

Test Plan:
- Identity/negation (defaults, conj=0): x=(1000,-2000), w=(-16384,0), in_valid=1 at cycle 0 -> cycle 4: out_valid=1, yr=-1000, yi=2000, sat=0.
- Rounding: x=(3,0), w=(8192,0) -> yr=2, yi=0. Next cycle x=(-3,0), same w -> yr=-1, yi=0.
- Saturation/conj:
  - x=(-8388608,-8388608), w=(-16384,-16384), conj=0 -> yr=0, yi=8388607, sat=1.
  - Same inputs with conj=1 -> yr=8388607, yi=0.
  - Then sat_clr=1 with a non-saturating input -> sat=0.
- Streaming with ce stall: 16 consecutive valid random samples, ce=0 for 3 cycles at cycle 5 -> 16 outputs matching the bit-true model in order, out_user aligned, outputs frozen during the stall, out_valid high for exactly 16 ce-cycles.
- Reset mid-flight: 3 valid samples issued, reset_n=0 for 1 cycle on cycle 2 -> no out_valid produced for those samples. yr=yi=0, sat=0. A sample issued after reset returns 4 cycles later.
- Parameter sweep: DIN_W=16, TW_W=18, DOUT_W=18, SHIFT=17, 10k random vectors with random conj -> bit-exact against the model, including sat and extremes (min*min).

Source files
------------

// File: rtl/fft_cmul_pipe_if.sv
// fft_cmul_pipe_if: sample bus for fft_cmul_pipe (data, twiddle and sideband in, result out)
interface fft_cmul_pipe_if #(
    parameter int DIN_W  = 24,
    parameter int TW_W   = 15,
    parameter int DOUT_W = 24,
    parameter int USER_W = 8
);
    logic                     in_valid;
    logic                     conj;
    logic signed [DIN_W-1:0]  xr, xi;
    logic signed [TW_W-1:0]   wr, wi;
    logic [USER_W-1:0]        in_user;
    logic                     out_valid;
    logic signed [DOUT_W-1:0] yr, yi;
    logic [USER_W-1:0]        out_user;
    modport master (output in_valid, conj, xr, xi, wr, wi, in_user, input out_valid, yr, yi, out_user);
    modport slave (input in_valid, conj, xr, xi, wr, wi, in_user, output out_valid, yr, yi, out_user);
endinterface

// File: rtl/fft_cmul_pipe.sv
// fft_cmul_pipe: 4-stage signed complex multiply x*w or x*conj(w) with round-half-up, shift and saturate
module fft_cmul_pipe #(
    parameter int DIN_W  = 24,
    parameter int TW_W   = 15,
    parameter int DOUT_W = 24,
    parameter int SHIFT  = 14,
    parameter int USER_W = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           ce,
    input  logic           sat_clr,
    output logic           sat,
    fft_cmul_pipe_if.slave bus
);
    localparam int PW = DIN_W + TW_W;
    localparam int P  = PW + 1;
    localparam logic signed [P:0] RND  = (P+1)'(1) <<< (SHIFT - 1);
    localparam logic signed [P:0] MAXV = {{(P+2-DOUT_W){1'b0}}, {(DOUT_W-1){1'b1}}};
    localparam logic signed [P:0] MINV = {{(P+2-DOUT_W){1'b1}}, {(DOUT_W-1){1'b0}}};

    logic                     v1, v2, v3, c1, c2;
    logic [USER_W-1:0]        u1, u2, u3;
    logic signed [DIN_W-1:0]  xr1, xi1;
    logic signed [TW_W-1:0]   wr1, wi1;
    logic signed [PW-1:0]     pp_rr, pp_ii, pp_ir, pp_ri;
    logic signed [P-1:0]      re3, im3;
    logic signed [P:0]        tr, ti;
    logic signed [DOUT_W-1:0] yr_n, yi_n;
    logic                     sat_r, sat_i;

    // one extra bit of headroom keeps the rounding add from overflowing
    always_comb begin
        tr    = ((P+1)'(re3) + RND) >>> SHIFT;
        ti    = ((P+1)'(im3) + RND) >>> SHIFT;
        sat_r = tr > MAXV || tr < MINV;
        sat_i = ti > MAXV || ti < MINV;
        yr_n  = tr > MAXV ? MAXV[DOUT_W-1:0] : tr < MINV ? MINV[DOUT_W-1:0] : tr[DOUT_W-1:0];
        yi_n  = ti > MAXV ? MAXV[DOUT_W-1:0] : ti < MINV ? MINV[DOUT_W-1:0] : ti[DOUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            {v1, v2, v3, c1, c2} <= '0;
            {u1, u2, u3}         <= '0;
            {xr1, xi1, wr1, wi1} <= '0;
            {pp_rr, pp_ii, pp_ir, pp_ri} <= '0;
            {re3, im3}           <= '0;
            bus.out_valid        <= 1'b0;
            bus.yr               <= '0;
            bus.yi               <= '0;
            bus.out_user         <= '0;
            sat                  <= 1'b0;
        end else if (ce) begin
            v1    <= bus.in_valid;
            c1    <= bus.conj;
            u1    <= bus.in_user;
            xr1   <= bus.xr;
            xi1   <= bus.xi;
            wr1   <= bus.wr;
            wi1   <= bus.wi;
            pp_rr <= PW'(xr1) * PW'(wr1);
            pp_ii <= PW'(xi1) * PW'(wi1);
            pp_ir <= PW'(xi1) * PW'(wr1);
            pp_ri <= PW'(xr1) * PW'(wi1);
            v2    <= v1;
            c2    <= c1;
            u2    <= u1;
            re3   <= c2 ? P'(pp_rr) + P'(pp_ii) : P'(pp_rr) - P'(pp_ii);
            im3   <= c2 ? P'(pp_ir) - P'(pp_ri) : P'(pp_ir) + P'(pp_ri);
            v3    <= v2;
            u3    <= u2;
            bus.out_valid <= v3;
            if (v3) begin
                bus.yr       <= yr_n;
                bus.yi       <= yi_n;
                bus.out_user <= u3;
            end
            // a saturation event in the clear cycle keeps the flag set
            sat <= (v3 && (sat_r || sat_i)) || (sat && !sat_clr);
        end
    end
endmodule

// File: tb/tb_fft_cmul_pipe.sv
// tb_fft_cmul_pipe: random and directed checks of two fft_cmul_pipe configurations against an arithmetic model
module tb_fft_cmul_pipe;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ce = 1'b1;
    logic sat_clr = 1'b0;
    logic sat_d, sat_s;
    int n_chk = 0;
    int n_ok = 0;

    always #5 clk = ~clk;

    fft_cmul_pipe_if #(.DIN_W(24), .TW_W(15), .DOUT_W(24), .USER_W(8)) di ();
    fft_cmul_pipe_if #(.DIN_W(16), .TW_W(18), .DOUT_W(18), .USER_W(8)) si ();

    fft_cmul_pipe #(.DIN_W(24), .TW_W(15), .DOUT_W(24), .SHIFT(14), .USER_W(8)) dut_d (
        .clk(clk), .reset_n(reset_n), .ce(ce), .sat_clr(sat_clr), .sat(sat_d), .bus(di));
    fft_cmul_pipe #(.DIN_W(16), .TW_W(18), .DOUT_W(18), .SHIFT(17), .USER_W(8)) dut_s (
        .clk(clk), .reset_n(reset_n), .ce(ce), .sat_clr(sat_clr), .sat(sat_s), .bus(si));

    longint ixr[2], ixi[2], iwr[2], iwi[2], oyr[2], oyi[2];
    logic iv[2], cj[2], ov[2], st[2];
    logic [7:0] iu[2], ou[2];
    assign ixr[0] = longint'(di.xr);  assign ixr[1] = longint'(si.xr);
    assign ixi[0] = longint'(di.xi);  assign ixi[1] = longint'(si.xi);
    assign iwr[0] = longint'(di.wr);  assign iwr[1] = longint'(si.wr);
    assign iwi[0] = longint'(di.wi);  assign iwi[1] = longint'(si.wi);
    assign oyr[0] = longint'(di.yr);  assign oyr[1] = longint'(si.yr);
    assign oyi[0] = longint'(di.yi);  assign oyi[1] = longint'(si.yi);
    assign iv[0] = di.in_valid;       assign iv[1] = si.in_valid;
    assign cj[0] = di.conj;           assign cj[1] = si.conj;
    assign ov[0] = di.out_valid;      assign ov[1] = si.out_valid;
    assign st[0] = sat_d;             assign st[1] = sat_s;
    assign iu[0] = di.in_user;        assign iu[1] = si.in_user;
    assign ou[0] = di.out_user;       assign ou[1] = si.out_user;

    typedef struct {
        longint yr, yi;
        bit sv;
        logic [7:0] u;
        int stamp;
    } ent_t;

    task automatic check(string tag, longint got, longint exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic longint rnd_sat(longint s, int sh, int dw, output bit o);
        longint t, mx, mn;
        mx = (64'sd1 <<< (dw - 1)) - 1;
        mn = -mx - 1;
        t  = (s + (64'sd1 <<< (sh - 1))) >>> sh;
        o  = t > mx || t < mn;
        return t > mx ? mx : t < mn ? mn : t;
    endfunction

    function automatic ent_t model(longint xr, xi, wr, wi, bit c, logic [7:0] u, int sh, int dw);
        ent_t e;
        bit o1, o2;
        longint re, im;
        re = c ? xr * wr + xi * wi : xr * wr - xi * wi;
        im = c ? xi * wr - xr * wi : xi * wr + xr * wi;
        e.yr = rnd_sat(re, sh, dw, o1);
        e.yi = rnd_sat(im, sh, dw, o2);
        e.sv = o1 | o2;
        e.u = u;
        e.stamp = 0;
        return e;
    endfunction

    // scoreboard per instance: outputs are due exactly 4 enabled cycles after acceptance
    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int SH = g ? 17 : 14;
        localparam int DW = g ? 18 : 24;
        ent_t q[$];
        int ccnt = 0;
        int npop = 0;
        longint hr = 0, hi = 0;
        logic [7:0] hu = 0;
        bit hov = 0, hsat = 0;
        always @(posedge clk) begin
            bit rn, c, clr, ev;
            ent_t e;
            rn = reset_n;
            c = ce;
            clr = sat_clr;
            if (rn && c) begin
                if (iv[g]) begin
                    e = model(ixr[g], ixi[g], iwr[g], iwi[g], cj[g], iu[g], SH, DW);
                    e.stamp = ccnt;
                    q.push_back(e);
                end
                ccnt++;
            end
            #1;
            if (!rn) begin
                q.delete();
                hr = 0; hi = 0; hu = 0; hov = 0; hsat = 0;
            end else if (c) begin
                ev = 0;
                hov = q.size() > 0 && q[0].stamp + 4 == ccnt;
                if (hov) begin
                    e = q.pop_front();
                    hr = e.yr; hi = e.yi; hu = e.u; ev = e.sv;
                    npop++;
                end
                hsat = ev | (hsat & !clr);
            end
            check(g ? "s.ov" : "d.ov", longint'(ov[g]), longint'(hov));
            check(g ? "s.yr" : "d.yr", oyr[g], hr);
            check(g ? "s.yi" : "d.yi", oyi[g], hi);
            check(g ? "s.user" : "d.user", longint'(ou[g]), longint'(hu));
            check(g ? "s.sat" : "d.sat", longint'(st[g]), longint'(hsat));
        end
    end

    task automatic send(longint xr, longint xi, longint wr, longint wi, bit c, logic [7:0] u);
        di.in_valid = 1'b1; di.conj = c; di.in_user = u;
        di.xr = 24'(xr); di.xi = 24'(xi); di.wr = 15'(wr); di.wi = 15'(wi);
        @(negedge clk);
        di.in_valid = 1'b0;
    endtask

    task automatic rand_d(bit v);
        di.in_valid = v; di.conj = 1'($urandom); di.in_user = 8'($urandom);
        di.xr = $urandom_range(3) == 0 ? 24'h800000 : 24'($urandom);
        di.xi = $urandom_range(3) == 0 ? 24'h800000 : 24'($urandom);
        di.wr = $urandom_range(3) == 0 ? 15'h4000 : 15'($urandom);
        di.wi = $urandom_range(3) == 0 ? 15'h4000 : 15'($urandom);
    endtask

    task automatic rand_s();
        si.in_valid = $urandom_range(7) != 0; si.conj = 1'($urandom); si.in_user = 8'($urandom);
        si.xr = $urandom_range(3) == 0 ? 16'h8000 : 16'($urandom);
        si.xi = $urandom_range(3) == 0 ? 16'h8000 : 16'($urandom);
        si.wr = $urandom_range(3) == 0 ? 18'h20000 : 18'($urandom);
        si.wi = $urandom_range(3) == 0 ? 18'h20000 : 18'($urandom);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n0;
        di.in_valid = 0; di.conj = 0; di.xr = 0; di.xi = 0; di.wr = 0; di.wi = 0; di.in_user = 0;
        si.in_valid = 0; si.conj = 0; si.xr = 0; si.xi = 0; si.wr = 0; si.wi = 0; si.in_user = 0;
        repeat (2) @(negedge clk);
        check("rst.ov", longint'(di.out_valid), 0);
        check("rst.yr", oyr[0], 0);
        check("rst.sat", longint'(sat_d), 0);
        reset_n = 1'b1;
        @(negedge clk);
        send(1000, -2000, -16384, 0, 0, 8'h11);
        repeat (3) @(posedge clk);
        #2;
        check("id.ov", longint'(di.out_valid), 1);
        check("id.yr", oyr[0], -1000);
        check("id.yi", oyi[0], 2000);
        check("id.user", longint'(di.out_user), 8'h11);
        check("id.sat", longint'(sat_d), 0);
        @(negedge clk);
        send(3, 0, 8192, 0, 0, 8'h21);
        send(-3, 0, 8192, 0, 0, 8'h22);
        repeat (2) @(posedge clk);
        #2;
        check("rnd.pos.yr", oyr[0], 2);
        check("rnd.pos.yi", oyi[0], 0);
        @(posedge clk);
        #2;
        check("rnd.neg.yr", oyr[0], -1);
        check("rnd.neg.yi", oyi[0], 0);
        @(negedge clk);
        send(-8388608, -8388608, -16384, -16384, 0, 8'h31);
        send(-8388608, -8388608, -16384, -16384, 1, 8'h32);
        repeat (2) @(posedge clk);
        #2;
        check("sat.yr", oyr[0], 0);
        check("sat.yi", oyi[0], 8388607);
        check("sat.flag", longint'(sat_d), 1);
        @(posedge clk);
        #2;
        check("conj.yr", oyr[0], 8388607);
        check("conj.yi", oyi[0], 0);
        @(negedge clk);
        sat_clr = 1'b1;
        send(5, 5, 100, 100, 0, 8'h33);
        sat_clr = 1'b0;
        check("satclr.flag", longint'(sat_d), 0);
        repeat (5) @(negedge clk);
        n0 = mon[0].npop;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                ce = 1'b0;
                repeat (3) begin rand_d(1'b1); @(negedge clk); end
                ce = 1'b1;
            end
            rand_d(1'b1);
            @(negedge clk);
        end
        di.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("strm.count", longint'(mon[0].npop - n0), 16);
        send(-8388608, 8388607, 16383, -16384, 0, 8'h41);
        repeat (4) @(negedge clk);
        rand_d(1'b1); @(negedge clk);
        rand_d(1'b1); @(negedge clk);
        rand_d(1'b1); reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        di.in_valid = 1'b0;
        check("rmf.ov", longint'(di.out_valid), 0);
        check("rmf.yr", oyr[0], 0);
        check("rmf.yi", oyi[0], 0);
        check("rmf.sat", longint'(sat_d), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rmf.quiet", longint'(di.out_valid), 0);
        end
        send(1000, -2000, -16384, 0, 0, 8'h51);
        repeat (3) @(posedge clk);
        #2;
        check("rmf.after.ov", longint'(di.out_valid), 1);
        check("rmf.after.yr", oyr[0], -1000);
        @(negedge clk);
        for (int i = 0; i < 10000; i++) begin
            ce = $urandom_range(9) != 0;
            sat_clr = $urandom_range(15) == 0;
            rand_s();
            rand_d($urandom_range(3) != 0);
            @(negedge clk);
        end
        ce = 1'b1;
        sat_clr = 1'b0;
        si.in_valid = 1'b0;
        di.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("d.drain", longint'(mon[0].q.size()), 0);
        check("s.drain", longint'(mon[1].q.size()), 0);
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
